exception_unit: RTL
===================

# exception_unit

Precise-exception responder for the single-cycle/pipelined LEGv8 core. Consumes the decoder's exception requests (NotAnInstr, ERet) plus an external interrupt line, records ELR/ESR, redirects fetch to the exception vector, and services ERET returns. Sits beside the MEM-stage control path; its registered outputs drive the PC mux, the pipeline flush, and the MRS read path.

## Interface

Parameters:
- N, 64, datapath/PC width
- VECTOR, 64'h0000_0000_0000_00D8, exception vector address

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- instr_valid  in  1  MEM stage holds a real instruction (not a bubble)
- NotAnInstr  in  1  undefined-opcode flag from decoder, qualified by instr_valid
- ERet  in  1  ERET flag from decoder, qualified by instr_valid
- ExtIRQ  in  1  external interrupt request, level
- pc_mem  in  N  PC of MEM-stage instruction
- sr_sel  in  2  MRS selector: 00 ELR, 01 ESR, 10 exception count, 11 zero
- sr_rdata  out  N  combinational system-register read data
- Exc  out  1  one-cycle pulse: PC <- EVAddr, flush MEM and younger
- EVAddr  out  N  constant VECTOR
- eret_taken  out  1  one-cycle pulse: PC <- elr
- elr  out  N  exception link register
- ExtIAck  out  1  one-cycle interrupt acknowledge
- in_handler  out  1  high in FLUSH and HANDLER
- halt  out  1  high in FATAL

## Operation

- States: IDLE, FLUSH, HANDLER, RETN, FATAL.
- IDLE, instr_valid=1, priority NotAnInstr > ERet > ExtIRQ:
  - NotAnInstr: ESR<-1, ELR<-pc_mem+4 (skip faulting instr), -> FLUSH.
  - ERet: illegal outside handler: ESR<-3, ELR<-pc_mem+4, -> FLUSH.
  - ExtIRQ: ESR<-2, ELR<-pc_mem (instr flushed, re-executed), -> FLUSH, irq_pending latched for ExtIAck.
  - none: stay IDLE.
- ExtIRQ with instr_valid=0 is not taken (waits for a valid boundary).
- FLUSH: Exc=1, ExtIAck=1 iff cause is 2, count++ (saturates at all-ones), all inputs ignored, -> HANDLER.
- HANDLER: ExtIRQ masked.
  - ERet & instr_valid & !NotAnInstr: -> RETN.
  - NotAnInstr & instr_valid (nested fault): -> FATAL, ESR<-4, ELR unchanged.
- RETN: eret_taken=1, elr stable, -> IDLE. ESR retained until next exception.
- FATAL: halt=1, all inputs ignored, exit only via reset.
- ELR/ESR/count written only on the IDLE->FLUSH (or HANDLER->FATAL for ESR) edge.
- pc_mem+4 wraps modulo 2^N.
- sr_rdata: ESR zero-extended from 3 bits; sel 11 -> 0.

## Timing

- Inputs sampled at rising clk; all control outputs registered (state-decoded).
- Detection in cycle t -> Exc/ExtIAck high in cycle t+1 only; ELR/ESR visible from t+1.
- Handler first fetch at VECTOR in cycle t+2.
- ERet detected in HANDLER at cycle t -> eret_taken high in t+1; IDLE at t+2.
- Minimum exception-to-next-exception spacing: FLUSH + ≥1 HANDLER cycle + RETN.
- Reset (any state, including FLUSH/RETN): next cycle state=IDLE, ELR=0, ESR=0, count=0, Exc=eret_taken=ExtIAck=halt=in_handler=0; an in-flight pulse is cancelled. EVAddr=VECTOR always.

## Structure

- Package exc_pkg: state enum, ESR cause codes (0 none, 1 undef, 2 irq, 3 illegal ERET, 4 nested fault), sr_sel codes.
- Sub-module exc_sysregs: ELR, ESR, saturating count registers plus sr_rdata read mux; FSM stays in exception_unit.

## Test plan

- Undefined opcode: IDLE, NotAnInstr=1, pc_mem=0x100 -> next cycle Exc=1, elr=0x104, ESR=1, count=1; following cycle in_handler=1, Exc=0.
- IRQ + return: ExtIRQ=1, pc_mem=0x200 -> Exc=1, ExtIAck=1, elr=0x200, ESR=2; later ERet in HANDLER -> eret_taken=1 one cycle, elr=0x200, state IDLE.
- Simultaneous NotAnInstr+ERet+ExtIRQ at pc_mem=0x300 -> ESR=1, ExtIAck=0, elr=0x304; ExtIRQ still high in HANDLER is not taken.
- Illegal ERET in IDLE at pc_mem=0x40 -> Exc=1, ESR=3, elr=0x44; instr_valid=0 with ExtIRQ=1 -> no Exc.
- Nested fault in HANDLER -> halt=1 held 10 cycles, ESR=4, elr unchanged; reset -> all outputs 0, sr_rdata=0 for every sr_sel.
- Wrap/saturation: pc_mem=all-ones fault -> elr=0x3; reset asserted during FLUSH -> Exc low next cycle, count=0.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types for the LEGv8 exception unit
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_HANDLER = 3'd2,
        ST_RETN    = 3'd3,
        ST_FATAL   = 3'd4
    } exc_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_UNDEF    = 3'd1,
        CAUSE_IRQ      = 3'd2,
        CAUSE_ILL_ERET = 3'd3,
        CAUSE_NESTED   = 3'd4
    } exc_cause_e;

    typedef enum logic [1:0] {
        SR_ELR   = 2'b00,
        SR_ESR   = 2'b01,
        SR_COUNT = 2'b10,
        SR_ZERO  = 2'b11
    } sr_sel_e;

endpackage

// File: rtl/exc_sysregs.sv
// rtl/exc_sysregs.sv - ELR/ESR/exception-count registers and MRS read mux
module exc_sysregs
    import exc_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         exc_we_i,
    input  logic         fatal_we_i,
    input  logic [N-1:0] elr_wdata_i,
    input  logic [2:0]   cause_wdata_i,
    input  logic [1:0]   sr_sel_i,
    output logic [N-1:0] elr_o,
    output logic [2:0]   esr_o,
    output logic [N-1:0] sr_rdata_o
);

    logic [N-1:0] elr_q;
    logic [2:0]   esr_q;
    logic [N-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            elr_q   <= '0;
            esr_q   <= CAUSE_NONE;
            count_q <= '0;
        end else if (exc_we_i) begin
            elr_q <= elr_wdata_i;
            esr_q <= cause_wdata_i;
            if (count_q != '1) begin
                count_q <= count_q + N'(1);
            end
        end else if (fatal_we_i) begin
            // A nested fault keeps the original return address for post-mortem.
            esr_q <= CAUSE_NESTED;
        end
    end

    always_comb begin
        sr_rdata_o = '0;
        case (sr_sel_i)
            SR_ELR:   sr_rdata_o = elr_q;
            SR_ESR:   sr_rdata_o = {{(N-3){1'b0}}, esr_q};
            SR_COUNT: sr_rdata_o = count_q;
            default:  sr_rdata_o = '0;
        endcase
    end

    assign elr_o = elr_q;
    assign esr_o = esr_q;

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - precise-exception FSM: vector redirect, flush and ERET return
module exception_unit
    import exc_pkg::*;
#(
    parameter int           N      = 64,
    parameter logic [N-1:0] VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic         NotAnInstr,
    input  logic         ERet,
    input  logic         ExtIRQ,
    input  logic [N-1:0] pc_mem,
    input  logic [1:0]   sr_sel,
    output logic [N-1:0] sr_rdata,
    output logic         Exc,
    output logic [N-1:0] EVAddr,
    output logic         eret_taken,
    output logic [N-1:0] elr,
    output logic         ExtIAck,
    output logic         in_handler,
    output logic         halt
);

    exc_state_e   state_q;
    logic         exc_take;
    logic         fatal_take;
    logic [2:0]   cause_d;
    logic [N-1:0] elr_d;
    logic [2:0]   esr;

    // Priority NotAnInstr > ERet > ExtIRQ; an IRQ re-executes the flushed instruction.
    always_comb begin
        cause_d = CAUSE_NONE;
        elr_d   = pc_mem;
        if (NotAnInstr) begin
            cause_d = CAUSE_UNDEF;
            elr_d   = pc_mem + N'(4);
        end else if (ERet) begin
            cause_d = CAUSE_ILL_ERET;
            elr_d   = pc_mem + N'(4);
        end else if (ExtIRQ) begin
            cause_d = CAUSE_IRQ;
        end
    end

    assign exc_take   = (state_q == ST_IDLE) && instr_valid && (NotAnInstr || ERet || ExtIRQ);
    assign fatal_take = (state_q == ST_HANDLER) && instr_valid && NotAnInstr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (exc_take) state_q <= ST_FLUSH;
                ST_FLUSH:   state_q <= ST_HANDLER;
                ST_HANDLER: begin
                    if (fatal_take) begin
                        state_q <= ST_FATAL;
                    end else if (instr_valid && ERet) begin
                        state_q <= ST_RETN;
                    end
                end
                ST_RETN:    state_q <= ST_IDLE;
                ST_FATAL:   state_q <= ST_FATAL;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    exc_sysregs #(.N(N)) u_sysregs (
        .clk_i         (clk),
        .reset_i       (reset),
        .exc_we_i      (exc_take),
        .fatal_we_i    (fatal_take),
        .elr_wdata_i   (elr_d),
        .cause_wdata_i (cause_d),
        .sr_sel_i      (sr_sel),
        .elr_o         (elr),
        .esr_o         (esr),
        .sr_rdata_o    (sr_rdata)
    );

    // ESR already holds the new cause during FLUSH, so the acknowledge can decode it.
    assign Exc        = (state_q == ST_FLUSH);
    assign ExtIAck    = (state_q == ST_FLUSH) && (esr == CAUSE_IRQ);
    assign eret_taken = (state_q == ST_RETN);
    assign in_handler = (state_q == ST_FLUSH) || (state_q == ST_HANDLER);
    assign halt       = (state_q == ST_FATAL);
    assign EVAddr     = VECTOR;

endmodule
